config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 12: total fabric configuration bits to load.
REQ-002 SHALL have parameter NUM_CHAINS, default 2: parallel configuration scan chains driven simultaneously.
REQ-003 SHALL have parameter WORD_WIDTH, default 4: host word width; integer multiple of NUM_CHAINS.
REQ-004 SHALL have parameter CLK_DIV, default 2 (>=1): clk cycles per config_clk phase, low and high each.
REQ-005 SHALL derive CHAIN_LEN = ceil(CONFIG_WIDTH/NUM_CHAINS), SLICES = WORD_WIDTH/NUM_CHAINS, NUM_WORDS = ceil(CHAIN_LEN/SLICES).
REQ-006 clk  input  1  single system clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a load.
REQ-009 abort  input  1  terminate an in-progress load.
REQ-010 word_in  input  WORD_WIDTH  host bitstream word.
REQ-011 word_valid  input  1  word_in valid.
REQ-012 word_ready  output  1  loader accepts word_in this cycle.
REQ-013 config_clk  output  1  fabric configuration clock; fabric samples on rising edge.
REQ-014 config_en  output  1  fabric configuration enable.
REQ-015 config_in  output  NUM_CHAINS  serial data, bit j drives chain j.
REQ-016 busy / done / error  output  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
REQ-018 IDLE: start=1 and abort=0 -> LOAD next cycle; busy=1, config_en=1, done=0, error=0 from that cycle.
REQ-019 LOAD: word_ready=1 only here; word accepted on word_valid&&word_ready, registered, slice index=0, -> SHIFT_LO next cycle.
REQ-020 Slice s of a word = word_in[s*NUM_CHAINS +: NUM_CHAINS]; slice 0 shifted first (LSB-first).
REQ-021 SHIFT_LO: config_in = current slice, config_clk=0 for CLK_DIV cycles, then SHIFT_HI.
REQ-022 SHIFT_HI: config_clk=1, config_in stable, for CLK_DIV cycles; shift counter increments by 1 at phase end.
REQ-023 End of SHIFT_HI: counter==CHAIN_LEN -> DONE; else slices remain in word -> SHIFT_LO next slice; else -> LOAD.
REQ-024 Exactly CHAIN_LEN config_clk rising edges per load; unused slices of the final word are discarded.
REQ-025 Word underrun (word_valid=0 in LOAD): wait indefinitely, config_clk held 0, config_en held 1, no error.
REQ-026 DONE: config_en=0, config_clk=0, busy=0, done=1 held until next accepted start.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort in LOAD/SHIFT_LO/SHIFT_HI: next cycle IDLE, config_en=0, config_clk=0, config_in=0, busy=0, error=1; abort overrides all same-cycle events including word acceptance.
REQ-029 abort in IDLE or DONE: no effect; start and abort together in IDLE: start ignored.
REQ-030 config_in SHALL change only while config_clk=0 (setup of CLK_DIV cycles before rising edge).

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counters 0, word_ready=0, config_clk=0, config_en=0, config_in=0, busy=0, done=0, error=0, including mid-shift.
REQ-032 After rst_n release, no activity until a start pulse.

Verification (defaults: CHAIN_LEN=6, SLICES=2, NUM_WORDS=3)
REQ-033 Assert rst_n=0 asynchronously -> all outputs 0 without a clk edge.
REQ-034 start, words 4'b1001, 4'b0110, 4'b1111 presented with valid=1 -> chain0 bits 1,0,0,1,1,1 and chain1 bits 0,1,1,0,1,1 at six config_clk rising edges, each period 4 clk; done=1 afterwards.
REQ-035 Hold word_valid=0 for 10 cycles after first word consumed -> config_clk stays 0, no extra edges, load completes with correct data once valid returns.
REQ-036 abort during third SHIFT_HI -> next cycle error=1, busy=0, config_en=0; subsequent start clears error and full load succeeds.
REQ-037 CONFIG_WIDTH=13: CHAIN_LEN=7, 4 words consumed, exactly 7 config_clk edges, slice 1 of word 4 never driven.
REQ-038 rst_n low mid-shift, then release and start -> clean full load from bit 0.

Source files
------------

// File: rtl/config_loader_if.sv
// Host word stream and fabric configuration pins of the configuration loader.
// The host side drives words in; the loader side drives the fabric pins.
interface config_loader_if #(
  parameter int WORD_WIDTH = 4,
  parameter int NUM_CHAINS = 2
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic                  config_clk;
  logic                  config_en;
  logic [NUM_CHAINS-1:0] config_in;

  modport master (
    output word_in, word_valid,
    input  word_ready, config_clk, config_en, config_in
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, config_clk, config_en, config_in
  );
endinterface

// File: rtl/config_loader.sv
// Loads host words into NUM_CHAINS parallel fabric scan chains, LSB slice first,
// generating a divided config_clk with data set up during the low phase.
//
// state    | meaning
// IDLE     | waiting for start; error holds the result of an aborted load
// LOAD     | word_ready high, waiting for the next host word
// SHIFT_LO | current slice on config_in, config_clk low for CLK_DIV cycles
// SHIFT_HI | config_clk high for CLK_DIV cycles; fabric samples on entry
// DONE     | CHAIN_LEN bits delivered; done held until the next start
module config_loader #(
  parameter int CONFIG_WIDTH = 12,
  parameter int NUM_CHAINS   = 2,
  parameter int WORD_WIDTH   = 4,
  parameter int CLK_DIV      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  config_loader_if.slave   bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int CHAIN_LEN = (CONFIG_WIDTH + NUM_CHAINS - 1) / NUM_CHAINS;
  localparam int SLICES    = WORD_WIDTH / NUM_CHAINS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int SLICE_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [SLICE_W-1:0]    slice_q, slice_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  error_q, error_d;
  logic                  shifting;
  logic [NUM_CHAINS-1:0] slice_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      slice_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slice_q <= slice_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    slice_d = slice_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    error_d = error_q;
    case (state_q)
      IDLE, DONE: begin
        // a simultaneous abort cancels the start request
        if (start && !abort) begin
          state_d = LOAD;
          error_d = 1'b0;
          cnt_d   = '0;
          slice_d = '0;
        end
      end
      LOAD, SHIFT_LO, SHIFT_HI: begin
        if (abort) begin
          state_d = IDLE;
          error_d = 1'b1;
          cnt_d   = '0;
          slice_d = '0;
          div_d   = '0;
        end else if (state_q == LOAD) begin
          if (bus.word_valid) begin
            word_d  = bus.word_in;
            slice_d = '0;
            div_d   = DIV_W'(CLK_DIV - 1);
            state_d = SHIFT_LO;
          end
        end else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (state_q == SHIFT_LO) begin
          div_d   = DIV_W'(CLK_DIV - 1);
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_d = DONE;
          end else if (slice_q == SLICE_W'(SLICES - 1)) begin
            state_d = LOAD;
          end else begin
            slice_d = slice_q + SLICE_W'(1);
            div_d   = DIV_W'(CLK_DIV - 1);
            state_d = SHIFT_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shifting   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
  assign slice_bits = word_q[slice_q*NUM_CHAINS +: NUM_CHAINS];

  assign busy           = shifting || (state_q == LOAD);
  assign done           = (state_q == DONE);
  assign error          = error_q;
  assign bus.word_ready = (state_q == LOAD);
  assign bus.config_clk = (state_q == SHIFT_HI);
  assign bus.config_en  = busy;
  assign bus.config_in  = shifting ? slice_bits : '0;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: default 12-bit instance for data, underrun,
// abort and reset cases, plus a 13-bit instance for the partial final word.
module tb_config_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic start_a, abort_a, busy_a, done_a, error_a;
  logic start_b, abort_b, busy_b, done_b, error_b;

  config_loader_if #(.WORD_WIDTH(4), .NUM_CHAINS(2)) bus_a ();
  config_loader_if #(.WORD_WIDTH(4), .NUM_CHAINS(2)) bus_b ();

  config_loader #(.CONFIG_WIDTH(12), .NUM_CHAINS(2), .WORD_WIDTH(4), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  config_loader #(.CONFIG_WIDTH(13), .NUM_CHAINS(2), .WORD_WIDTH(4), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  // host word feeders: present the next word whenever the loader is ready
  logic [3:0] words_a [8];
  logic [3:0] words_b [8];
  int n_words_a = 0, idx_a = 0;
  int n_words_b = 0, idx_b = 0;

  always @(negedge clk) begin
    if (start_a && !busy_a) idx_a = 0;
    if (bus_a.word_ready && idx_a < n_words_a) begin
      bus_a.word_in = words_a[idx_a];
      bus_a.word_valid = 1'b1;
      idx_a++;
    end else begin
      bus_a.word_in = 4'h0;
      bus_a.word_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (start_b && !busy_b) idx_b = 0;
    if (bus_b.word_ready && idx_b < n_words_b) begin
      bus_b.word_in = words_b[idx_b];
      bus_b.word_valid = 1'b1;
      idx_b++;
    end else begin
      bus_b.word_in = 4'h0;
      bus_b.word_valid = 1'b0;
    end
  end

  // config_clk monitors: capture data at each rising edge, check phase lengths
  logic [1:0] cap_a [$];
  logic [1:0] cap_b [$];
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [1:0] hi_data_a, hi_data_b;
  int hi_run_a = 0, lo_run_a = 0, bad_a = 0;
  int hi_run_b = 0, lo_run_b = 0, bad_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = 1'b0; hi_run_a = 0; lo_run_a = 0;
    end else begin
      if (bus_a.config_clk === 1'b1) begin
        if (!prev_a) begin
          cap_a.push_back(bus_a.config_in);
          hi_data_a = bus_a.config_in;
          if (lo_run_a < 2) bad_a++;
          hi_run_a = 1;
        end else begin
          hi_run_a++;
          if (bus_a.config_in !== hi_data_a) bad_a++;
        end
        lo_run_a = 0;
      end else begin
        if (prev_a && hi_run_a != 2 && !error_a) bad_a++;
        lo_run_a++;
      end
      prev_a = (bus_a.config_clk === 1'b1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_b = 1'b0; hi_run_b = 0; lo_run_b = 0;
    end else begin
      if (bus_b.config_clk === 1'b1) begin
        if (!prev_b) begin
          cap_b.push_back(bus_b.config_in);
          hi_data_b = bus_b.config_in;
          if (lo_run_b < 2) bad_b++;
          hi_run_b = 1;
        end else begin
          hi_run_b++;
          if (bus_b.config_in !== hi_data_b) bad_b++;
        end
        lo_run_b = 0;
      end else begin
        if (prev_b && hi_run_b != 2 && !error_b) bad_b++;
        lo_run_b++;
      end
      prev_b = (bus_b.config_clk === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] st_a();
    return {bus_a.word_ready, bus_a.config_clk, bus_a.config_en, bus_a.config_in,
            busy_a, done_a, error_a};
  endfunction

  function automatic logic [7:0] st_b();
    return {bus_b.word_ready, bus_b.config_clk, bus_b.config_en, bus_b.config_in,
            busy_b, done_b, error_b};
  endfunction

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (done_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, done_a, 1);
  endtask

  typedef struct {
    logic [3:0] w0, w1, w2;
    int         stall;
    bit         extra_start;
    logic [5:0] c0, c1;   // bit i = value at config_clk rising edge i
  } vec_t;

  vec_t vecs [3];

  task automatic run_vec_a(input vec_t v, input string tag);
    int base, n, e0, bad_stall;
    logic [5:0] a0, a1;
    base = cap_a.size();
    words_a[0] = v.w0; words_a[1] = v.w1; words_a[2] = v.w2;
    n_words_a = (v.stall > 0) ? 1 : 3;
    pulse_start_a();
    if (v.stall > 0) begin
      n = 0;
      while (!(cap_a.size() - base == 2 && bus_a.word_ready) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check({tag, " reach underrun"}, n < 200, 1);
      if (v.extra_start) pulse_start_a();
      e0 = cap_a.size();
      bad_stall = 0;
      repeat (v.stall) begin
        @(negedge clk);
        if (bus_a.config_clk !== 1'b0 || bus_a.config_en !== 1'b1 || busy_a !== 1'b1 ||
            error_a !== 1'b0)
          bad_stall++;
      end
      check({tag, " underrun hold"}, bad_stall, 0);
      check({tag, " underrun edges"}, cap_a.size() - e0, 0);
      n_words_a = 3;
    end
    wait_done_a(tag);
    check({tag, " edge count"}, cap_a.size() - base, 6);
    a0 = '0; a1 = '0;
    for (int i = 0; i < 6; i++) begin
      if (base + i < cap_a.size()) begin
        a0[i] = cap_a[base + i][0];
        a1[i] = cap_a[base + i][1];
      end
    end
    check({tag, " chain0"}, a0, v.c0);
    check({tag, " chain1"}, a1, v.c1);
    check({tag, " final status"}, st_a(), 8'b0000_0010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n, e0;
    logic [6:0] b0, b1;

    vecs[0] = '{w0: 4'b1001, w1: 4'b0110, w2: 4'b1111, stall: 0,  extra_start: 1'b0,
                c0: 6'b111001, c1: 6'b110110};
    vecs[1] = '{w0: 4'b0000, w1: 4'b1111, w2: 4'b0101, stall: 10, extra_start: 1'b0,
                c0: 6'b111100, c1: 6'b001100};
    vecs[2] = '{w0: 4'b1010, w1: 4'b0011, w2: 4'b1100, stall: 4,  extra_start: 1'b1,
                c0: 6'b100100, c1: 6'b100111};

    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset status a", st_a(), 8'h00);
    check("reset status b", st_b(), 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (4) @(negedge clk);
    check("idle after reset", st_a(), 8'h00);

    // start together with abort in IDLE is ignored
    @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
    @(negedge clk);
    check("start+abort idle", st_a(), 8'h00);

    for (int k = 0; k < 3; k++) run_vec_a(vecs[k], $sformatf("vec%0d", k));

    // abort during the third config_clk high phase
    base = cap_a.size();
    words_a[0] = vecs[0].w0; words_a[1] = vecs[0].w1; words_a[2] = vecs[0].w2;
    n_words_a = 3;
    pulse_start_a();
    n = 0;
    while (!(cap_a.size() - base == 3 && bus_a.config_clk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort reach third high", n < 200, 1);
    abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    check("abort status", st_a(), 8'b0000_0001);
    e0 = cap_a.size();
    repeat (6) @(negedge clk);
    check("abort no edges", cap_a.size() - e0, 0);
    check("abort error held", error_a, 1);
    run_vec_a(vecs[0], "reload");

    // abort in DONE has no effect
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    check("abort in done", st_a(), 8'b0000_0010);

    // asynchronous reset in the middle of a shift
    base = cap_a.size();
    n_words_a = 3;
    pulse_start_a();
    n = 0;
    while (!(cap_a.size() - base == 2 && bus_a.config_clk) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach mid shift", n < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mid shift", st_a(), 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    e0 = cap_a.size();
    repeat (6) @(negedge clk);
    check("quiet after reset", st_a(), 8'h00);
    check("quiet edges", cap_a.size() - e0, 0);
    run_vec_a(vecs[0], "post reset");
    check("phase timing a", bad_a, 0);

    // 13-bit instance: 7 bits per chain, second slice of word 4 dropped
    words_b[0] = 4'b1101; words_b[1] = 4'b0010; words_b[2] = 4'b1011; words_b[3] = 4'b0111;
    n_words_b = 4;
    base = cap_b.size();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b done", done_b, 1);
    check("b edge count", cap_b.size() - base, 7);
    check("b words consumed", idx_b, 4);
    b0 = '0; b1 = '0;
    for (int i = 0; i < 7; i++) begin
      if (base + i < cap_b.size()) begin
        b0[i] = cap_b[base + i][0];
        b1[i] = cap_b[base + i][1];
      end
    end
    check("b chain0", b0, 7'b1010011);
    check("b chain1", b1, 7'b1110110);
    repeat (6) @(negedge clk);
    check("b no extra edges", cap_b.size() - base, 7);
    check("b final status", st_b(), 8'b0000_0010);
    check("phase timing b", bad_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
